// File: rtl/dec_exec_pkg.sv
// Shared decode/execute packet definitions and buffer sizing limits.
package dec_exec_pkg;

    // Width of one decode-to-execute packet.
    localparam int unsigned DEC_EXEC_PKT_W = 8;

    // Legal entry-count range for dec_exec_buf.
    localparam int unsigned DEC_EXEC_BUF_MIN_DEPTH = 2;
    localparam int unsigned DEC_EXEC_BUF_MAX_DEPTH = 16;

    typedef logic [DEC_EXEC_PKT_W-1:0] dec_exec_pkt_t;

endpackage

// File: rtl/dec_exec_buf_ptr.sv
// Modulo-DEPTH incrementing pointer with synchronous clear.
// DEPTH need not be a power of two; the pointer wraps from DEPTH-1 to 0.
module dec_exec_buf_ptr #(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Next pointer: clear wins over increment; wrap at the last entry.
    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            if (ptr_q == PTR_W'(DEPTH - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end
    end

    // Pointer state, asynchronously cleared.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/dec_exec_buf.sv
// Decode-to-execute packet buffer: DEPTH-entry circular FIFO with valid/ready
// handshakes on both sides and a synchronous flush for branch redirects.
// Optional feature macro DEC_EXEC_BUF_BYPASS_EN: when the buffer is empty and
// the execute side is ready, the incoming packet is forwarded combinationally.
module dec_exec_buf
    import dec_exec_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = $bits(dec_exec_pkt_t),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_pkt,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_pkt,
    input  logic             flush,
    output logic [CNT_W-1:0] count
);

    if (DEPTH < DEC_EXEC_BUF_MIN_DEPTH || DEPTH > DEC_EXEC_BUF_MAX_DEPTH) begin : g_bad_depth
        $error("dec_exec_buf: DEPTH %0d outside legal range 2..16", DEPTH);
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             full;
    logic             empty;
    logic             bypass;
    logic             push;
    logic             pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // Ready depends only on occupancy and flush, never on out_rdy or in_vld.
    assign in_rdy = !full && !flush;

`ifdef DEC_EXEC_BUF_BYPASS_EN
    // Empty buffer with a ready consumer: hand the packet straight through.
    assign bypass  = empty && in_vld && out_rdy && !flush;
    assign out_vld = (!empty || bypass) && !flush;
    assign out_pkt = bypass ? in_pkt : mem[rd_ptr];
`else
    assign bypass  = 1'b0;
    assign out_vld = !empty && !flush;
    assign out_pkt = mem[rd_ptr];
`endif

    // A bypassed packet is consumed in flight and never touches the storage.
    assign push = in_vld && in_rdy && !bypass;
    assign pop  = out_vld && out_rdy && !bypass;

    // Occupancy next state; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Occupancy register, asynchronously cleared.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Storage write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_pkt;
        end
    end

    dec_exec_buf_ptr #(
        .DEPTH (DEPTH)
    ) u_rd_ptr (
        .clk    (clk),
        .resetn (resetn),
        .clr    (flush),
        .inc    (pop),
        .ptr    (rd_ptr)
    );

    dec_exec_buf_ptr #(
        .DEPTH (DEPTH)
    ) u_wr_ptr (
        .clk    (clk),
        .resetn (resetn),
        .clr    (flush),
        .inc    (push),
        .ptr    (wr_ptr)
    );

    assign count = count_q;

endmodule

// File: tb/tb_dec_exec_buf.sv
// Directed bench for dec_exec_buf: three instances (DEPTH 2, 3, 4) share one
// clock and reset; each scenario drives one instance.
module tb_dec_exec_buf;

    localparam int unsigned W = dec_exec_pkg::DEC_EXEC_PKT_W;

    logic         clk;
    logic         resetn;
    logic         in_vld  [3];
    logic         in_rdy  [3];
    logic [W-1:0] in_pkt  [3];
    logic         out_vld [3];
    logic         out_rdy [3];
    logic [W-1:0] out_pkt [3];
    logic         flush   [3];
    logic [2:0]   count   [3];

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned D = g + 2;
        logic [$clog2(D+1)-1:0] cnt;

        dec_exec_buf #(
            .DEPTH (D),
            .WIDTH (W)
        ) u_dut (
            .clk     (clk),
            .resetn  (resetn),
            .in_vld  (in_vld[g]),
            .in_rdy  (in_rdy[g]),
            .in_pkt  (in_pkt[g]),
            .out_vld (out_vld[g]),
            .out_rdy (out_rdy[g]),
            .out_pkt (out_pkt[g]),
            .flush   (flush[g]),
            .count   (cnt)
        );

        assign count[g] = 3'(cnt);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic drv(input int k, input logic v, input logic [W-1:0] p, input logic r);
        in_vld[k]  = v;
        in_pkt[k]  = p;
        out_rdy[k] = r;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            in_vld[k]  = 1'b0;
            in_pkt[k]  = '0;
            out_rdy[k] = 1'b0;
            flush[k]   = 1'b0;
        end
        resetn = 1'b0;
        #23;
        resetn = 1'b1;
        step();

        // Reset state of every instance.
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_count%0d", k), 32'(count[k]), 0);
            check($sformatf("rst_in_rdy%0d", k), 32'(in_rdy[k]), 1);
            check($sformatf("rst_out_vld%0d", k), 32'(out_vld[k]), 0);
        end

        // DEPTH=2: fill with consumer stalled, then drain in order.
        drv(0, 1'b1, 8'hA1, 1'b0);
        step();
        drv(0, 1'b1, 8'hA2, 1'b0);
        step();
        drv(0, 1'b0, 8'h00, 1'b0);
        check("d2_count_full", 32'(count[0]), 2);
        check("d2_in_rdy_full", 32'(in_rdy[0]), 0);
        check("d2_out_vld", 32'(out_vld[0]), 1);
        check("d2_head_A1", 32'(out_pkt[0]), 32'hA1);
        step();
        check("d2_hold_A1", 32'(out_pkt[0]), 32'hA1);
        drv(0, 1'b0, 8'h00, 1'b1);
        check("d2_first_out", 32'(out_pkt[0]), 32'hA1);
        step();
        check("d2_second_out", 32'(out_pkt[0]), 32'hA2);
        check("d2_count_1", 32'(count[0]), 1);
        step();
        check("d2_count_0", 32'(count[0]), 0);
        check("d2_out_vld_0", 32'(out_vld[0]), 0);
        drv(0, 1'b0, 8'h00, 1'b0);

        // DEPTH=3: one push, then six push+pop cycles across the pointer wrap.
        drv(1, 1'b1, 8'h10, 1'b0);
        step();
        for (int i = 0; i < 6; i++) begin
            drv(1, 1'b1, 8'(8'h11 + i), 1'b1);
            check($sformatf("d3_order%0d", i), 32'(out_pkt[1]), 32'(8'h10 + i));
            step();
            check($sformatf("d3_count_hold%0d", i), 32'(count[1]), 1);
        end
        drv(1, 1'b0, 8'h00, 1'b1);
        check("d3_last_out", 32'(out_pkt[1]), 32'h16);
        step();
        check("d3_count_0", 32'(count[1]), 0);
        drv(1, 1'b0, 8'h00, 1'b0);

        // DEPTH=4: full buffer rejects a push even while popping.
        for (int i = 0; i < 4; i++) begin
            drv(2, 1'b1, 8'(8'h20 + i), 1'b0);
            step();
        end
        drv(2, 1'b1, 8'h99, 1'b1);
        check("d4_count_full", 32'(count[2]), 4);
        check("d4_in_rdy_full", 32'(in_rdy[2]), 0);
        check("d4_head", 32'(out_pkt[2]), 32'h20);
        step();
        drv(2, 1'b0, 8'h00, 1'b0);
        check("d4_count_3", 32'(count[2]), 3);
        check("d4_in_rdy_after", 32'(in_rdy[2]), 1);
        check("d4_next_head", 32'(out_pkt[2]), 32'h21);

        // Flush at count=3 with a packet offered: it must vanish.
        flush[2] = 1'b1;
        drv(2, 1'b1, 8'h77, 1'b0);
        check("fl_out_vld", 32'(out_vld[2]), 0);
        check("fl_in_rdy", 32'(in_rdy[2]), 0);
        step();
        flush[2] = 1'b0;
        drv(2, 1'b0, 8'h00, 1'b0);
        check("fl_count_0", 32'(count[2]), 0);
        check("fl_out_vld_after", 32'(out_vld[2]), 0);
        drv(2, 1'b1, 8'h30, 1'b0);
        step();
        drv(2, 1'b0, 8'h00, 1'b0);
        check("fl_first_after", 32'(out_pkt[2]), 32'h30);
        check("fl_count_1", 32'(count[2]), 1);
        drv(2, 1'b0, 8'h00, 1'b1);
        step();
        drv(2, 1'b0, 8'h00, 1'b0);
        check("fl_drained", 32'(count[2]), 0);

        // Asynchronous reset mid-stream at count=2.
        drv(2, 1'b1, 8'h40, 1'b0);
        step();
        drv(2, 1'b1, 8'h41, 1'b0);
        step();
        drv(2, 1'b0, 8'h00, 1'b0);
        check("rs_count_2", 32'(count[2]), 2);
        #2;
        resetn = 1'b0;
        #1;
        check("rs_count_async", 32'(count[2]), 0);
        check("rs_out_vld_async", 32'(out_vld[2]), 0);
        check("rs_in_rdy_async", 32'(in_rdy[2]), 1);
        #3;
        resetn = 1'b1;
        drv(2, 1'b1, 8'h55, 1'b0);
        step();
        drv(2, 1'b0, 8'h00, 1'b0);
        check("rs_first_out", 32'(out_pkt[2]), 32'h55);
        check("rs_count_1", 32'(count[2]), 1);
        drv(2, 1'b0, 8'h00, 1'b1);
        step();
        drv(2, 1'b0, 8'h00, 1'b0);

        // Empty buffer, producer and consumer both ready.
        drv(0, 1'b1, 8'h3C, 1'b1);
`ifdef DEC_EXEC_BUF_BYPASS_EN
        check("bp_out_vld", 32'(out_vld[0]), 1);
        check("bp_out_pkt", 32'(out_pkt[0]), 32'h3C);
        check("bp_in_rdy", 32'(in_rdy[0]), 1);
        step();
        drv(0, 1'b0, 8'h00, 1'b1);
        check("bp_count_0", 32'(count[0]), 0);
        check("bp_out_vld_after", 32'(out_vld[0]), 0);
`else
        check("nb_out_vld_same", 32'(out_vld[0]), 0);
        step();
        drv(0, 1'b0, 8'h00, 1'b1);
        check("nb_out_vld_next", 32'(out_vld[0]), 1);
        check("nb_out_pkt_next", 32'(out_pkt[0]), 32'h3C);
        check("nb_count_1", 32'(count[0]), 1);
        step();
        check("nb_count_0", 32'(count[0]), 0);
`endif
        drv(0, 1'b0, 8'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dec_exec_buf.md
DEC_EXEC_BUF -- requirements
Module: dec_exec_buf

Interface
REQ-001 SHALL have parameter: DEPTH, 2, number of packet entries held (legal range 2..16).
REQ-002 SHALL have parameter: WIDTH, DEC_EXEC_PKT_W, packet width in bits.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port: resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: in_vld  input  1  decode-side packet valid.
REQ-006 SHALL have port: in_rdy  output  1  buffer can accept a packet this cycle.
REQ-007 SHALL have port: in_pkt  input  WIDTH  decode-side packet.
REQ-008 SHALL have port: out_vld  output  1  execute-side packet valid.
REQ-009 SHALL have port: out_rdy  input  1  execute stage accepts the packet this cycle.
REQ-010 SHALL have port: out_pkt  output  WIDTH  execute-side packet (oldest entry).
REQ-011 SHALL have port: flush  input  1  synchronous discard of all held packets (branch redirect).
REQ-012 SHALL have port: count  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-013 SHALL store packets in a DEPTH-entry circular buffer with read pointer, write pointer and occupancy counter; strict FIFO order.
REQ-014 SHALL transfer on a port only in a cycle where vld and rdy are both 1 at posedge clk.
REQ-015 SHALL drive in_rdy = (count < DEPTH) && !flush, with no combinational dependence on out_rdy or in_vld.
REQ-016 SHALL drive out_vld = (count != 0) && !flush, out_pkt = entry at read pointer; out_pkt is don't-care when out_vld = 0.
REQ-017 SHALL hold out_pkt stable while out_vld = 1 and out_rdy = 0.
REQ-018 SHALL give a minimum latency of 1 cycle: packet accepted at edge N is presented on out_pkt after edge N.
REQ-019 SHALL, on simultaneous push and pop, update both pointers and leave count unchanged.
REQ-020 SHALL, when full, reject the push even if a pop occurs in the same cycle (no pass-through on full).
REQ-021 SHALL wrap each pointer from DEPTH-1 to 0; DEPTH need not be a power of two.
REQ-022 SHALL, when flush = 1 at posedge, set count and both pointers to 0 and discard any in_pkt offered that cycle.
REQ-023 SHALL never overflow or underflow count; a push with in_rdy = 0 or a pop with out_vld = 0 has no effect.

Reset
REQ-024 SHALL, on resetn low, asynchronously clear count, read and write pointers; in_rdy = 1, out_vld = 0, count = 0 while reset is deasserted afterwards.
REQ-025 SHALL not reset the storage array; contents are unobservable until written.
REQ-026 SHALL, on reset mid-operation, discard all held packets; first post-reset push is the first packet out.

Configuration
REQ-027 SHALL, with DEC_EXEC_BUF_BYPASS_EN defined, pass in_pkt to out_pkt combinationally when count = 0, in_vld = 1, out_rdy = 1 and flush = 0; out_vld = 1, no write, count stays 0 (zero latency).
REQ-028 SHALL, without DEC_EXEC_BUF_BYPASS_EN, never create an in-to-out combinational path; REQ-018 applies unconditionally.
REQ-029 SHALL, in bypass mode, keep in_rdy independent of out_rdy (REQ-015 unchanged).

Structure
REQ-030 SHALL take dec_exec_pkt_t and DEC_EXEC_PKT_W from shared package dec_exec_pkg; no new typedefs local to the module.
REQ-031 SHALL implement pointers with one sub-module, dec_exec_buf_ptr (parametrised modulo-DEPTH incrementing counter with clear), instantiated twice.
REQ-032 SHALL reject DEPTH < 2 or DEPTH > 16 at elaboration.

Verification
REQ-033 SHALL cover: DEPTH=2, push 0xA1, 0xA2 with out_rdy=0 -> count=2, in_rdy=0; then out_rdy=1 -> 0xA1 then 0xA2 out, count 0.
REQ-034 SHALL cover: DEPTH=3, 7 pushes/pops interleaved with simultaneous push+pop at count=1 -> order preserved across pointer wrap, count holds at 1.
REQ-035 SHALL cover: full buffer (DEPTH=4), in_vld=1 and out_rdy=1 same cycle -> one pop, no push, count=3, in_rdy=1 next cycle.
REQ-036 SHALL cover: count=3, flush=1 with in_vld=1 -> out_vld=0 and in_rdy=0 that cycle, count=0 after edge, offered packet never appears.
REQ-037 SHALL cover: resetn pulsed low mid-stream at count=2 -> count=0, out_vld=0 immediately; next push 0x55 is first out.
REQ-038 SHALL cover: with DEC_EXEC_BUF_BYPASS_EN, empty buffer, in_vld=1, in_pkt=0x3C, out_rdy=1 -> out_vld=1, out_pkt=0x3C same cycle, count stays 0; without macro -> out_vld=1 one cycle later.
